// File: rtl/cpu_bp_pkg.sv
// Shared branch-predictor helpers.
// Holds the saturating-counter constants and the bit-position helpers that
// split a PC into set index and tag. Everything is a function of the module
// parameters so that users can size their own slices as local parameters.
package cpu_bp_pkg;

    // Largest value of a CTR_WIDTH-bit counter (all ones).
    function automatic logic [31:0] ctr_max(input int unsigned w);
        return (32'd1 << w) - 32'd1;
    endfunction

    // Weakly-taken initial value: MSB set, every other bit clear.
    function automatic logic [31:0] ctr_weak_taken(input int unsigned w);
        return 32'd1 << (w - 32'd1);
    endfunction

    // Lowest address bit that feeds the set index.
    function automatic int unsigned set_lsb(input int unsigned byte_offset);
        return byte_offset;
    endfunction

    // Lowest address bit that belongs to the tag.
    function automatic int unsigned tag_lsb(input int unsigned byte_offset,
                                            input int unsigned set_width);
        return byte_offset + set_width;
    endfunction

endpackage

// File: rtl/cpu_sat_counter.sv
// Saturating up/down counter step (combinational).
// Ports:
//   ctr_i  current counter value
//   inc_i  1 = count up, 0 = count down
//   ctr_o  next value, clamped at all-ones and at zero
module cpu_sat_counter
    import cpu_bp_pkg::*;
#(
    parameter int W = 2
) (
    input  logic [W-1:0] ctr_i,
    input  logic         inc_i,
    output logic [W-1:0] ctr_o
);

    localparam logic [31:0]  MAX32   = ctr_max(W);
    localparam logic [W-1:0] CTR_MAX = MAX32[W-1:0];
    localparam logic [W-1:0] CTR_MIN = {W{1'b0}};
    localparam logic [W-1:0] CTR_ONE = {{(W-1){1'b0}}, 1'b1};

    // Next counter value with clamping at both ends.
    always_comb begin
        ctr_o = ctr_i;
        if (inc_i) begin
            if (ctr_i == CTR_MAX) ctr_o = ctr_i;
            else                  ctr_o = ctr_i + CTR_ONE;
        end else begin
            if (ctr_i == CTR_MIN) ctr_o = ctr_i;
            else                  ctr_o = ctr_i - CTR_ONE;
        end
    end

endmodule

// File: rtl/cpu_btb_predictor.sv
// Set-associative branch target buffer with per-entry saturating direction
// counters and optional gshare indexing from a speculative global history.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   lookup_valid, lookup_addr       fetch lookup (advances history)
//   pred_hit/taken/target/hist      combinational prediction + history used
//   update, update_addr/hist/taken/target/mispredict
//                                   resolved-branch training port
module cpu_btb_predictor
    import cpu_bp_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int CTR_WIDTH   = 2,
    parameter int BYTE_OFFSET = 2,
    parameter int SET_WIDTH   = 5,
    parameter int N_WIDTH     = 1,
    parameter int HIST_WIDTH  = 4,
    localparam int HW         = (HIST_WIDTH > 0) ? HIST_WIDTH : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            lookup_valid,
    input  logic [XLEN-1:0] lookup_addr,
    output logic            pred_hit,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    output logic [HW-1:0]   pred_hist,
    input  logic            update,
    input  logic [XLEN-1:0] update_addr,
    input  logic [HW-1:0]   update_hist,
    input  logic            update_taken,
    input  logic [XLEN-1:0] update_target,
    input  logic            update_mispredict
);

    localparam int NSETS   = 1 << SET_WIDTH;
    localparam int NWAYS   = 1 << N_WIDTH;
    localparam int SET_LO  = set_lsb(BYTE_OFFSET);
    localparam int TAG_LO  = tag_lsb(BYTE_OFFSET, SET_WIDTH);
    localparam int TAG_W   = XLEN - TAG_LO;
    localparam logic [31:0] WEAK32 = ctr_weak_taken(CTR_WIDTH);
    localparam logic [CTR_WIDTH-1:0] CTR_WEAK = WEAK32[CTR_WIDTH-1:0];

    logic [NWAYS-1:0]     valid_q  [NSETS];
    logic [TAG_W-1:0]     tag_q    [NSETS][NWAYS];
    logic [XLEN-1:0]      target_q [NSETS][NWAYS];
    logic [CTR_WIDTH-1:0] ctr_q    [NSETS][NWAYS];
    logic [N_WIDTH-1:0]   rr_q     [NSETS];
    logic [HW-1:0]        ghr_q, ghr_d;

    logic [SET_WIDTH-1:0] l_set_s, u_set_s;
    logic [TAG_W-1:0]     l_tag_s, u_tag_s;
    logic                 u_hit_s, inv_found_s;
    logic [N_WIDTH-1:0]   u_way_s, inv_way_s, victim_s;
    logic [CTR_WIDTH-1:0] u_ctr_next_s;
    logic [HW:0]          upd_shift_s, look_shift_s;
    logic                 unused_ok_s;

    // Byte-offset bits never address the table.
    assign unused_ok_s = ^{lookup_addr[BYTE_OFFSET-1:0], update_addr[BYTE_OFFSET-1:0]};

    // Zero-extend the history onto the set index; no history means plain indexing.
    function automatic logic [SET_WIDTH-1:0] hash_set(input logic [SET_WIDTH-1:0] s,
                                                      input logic [HW-1:0] h);
        logic [SET_WIDTH-1:0] hx;
        hx = (HIST_WIDTH > 0) ? SET_WIDTH'(h) : {SET_WIDTH{1'b0}};
        return s ^ hx;
    endfunction

    assign l_set_s = hash_set(lookup_addr[SET_LO +: SET_WIDTH], ghr_q);
    assign l_tag_s = lookup_addr[TAG_LO +: TAG_W];
    // Training indexes with the history seen at prediction time, not today's GHR.
    assign u_set_s = hash_set(update_addr[SET_LO +: SET_WIDTH], update_hist);
    assign u_tag_s = update_addr[TAG_LO +: TAG_W];

    // Lookup: at most one way can match, so OR-style selection is safe.
    always_comb begin
        pred_hit    = 1'b0;
        pred_taken  = 1'b0;
        pred_target = {XLEN{1'b0}};
        for (int w = 0; w < NWAYS; w++) begin
            if (valid_q[l_set_s][w] && (tag_q[l_set_s][w] == l_tag_s)) begin
                pred_hit    = 1'b1;
                pred_taken  = ctr_q[l_set_s][w][CTR_WIDTH-1];
                pred_target = target_q[l_set_s][w];
            end else begin
                pred_hit    = pred_hit;
            end
        end
    end

    assign pred_hist = ghr_q;

    // Update side: hit way, lowest invalid way, and allocation victim.
    always_comb begin
        u_hit_s     = 1'b0;
        u_way_s     = {N_WIDTH{1'b0}};
        inv_found_s = 1'b0;
        inv_way_s   = {N_WIDTH{1'b0}};
        for (int w = 0; w < NWAYS; w++) begin
            if (valid_q[u_set_s][w] && (tag_q[u_set_s][w] == u_tag_s)) begin
                u_hit_s = 1'b1;
                u_way_s = N_WIDTH'(w);
            end else begin
                u_hit_s = u_hit_s;
            end
        end
        // Descending scan so the lowest-numbered invalid way wins.
        for (int w = NWAYS - 1; w >= 0; w--) begin
            if (!valid_q[u_set_s][w]) begin
                inv_found_s = 1'b1;
                inv_way_s   = N_WIDTH'(w);
            end else begin
                inv_found_s = inv_found_s;
            end
        end
        victim_s = inv_found_s ? inv_way_s : rr_q[u_set_s];
    end

    cpu_sat_counter #(.W(CTR_WIDTH)) u_sat (
        .ctr_i (ctr_q[u_set_s][u_way_s]),
        .inc_i (update_taken),
        .ctr_o (u_ctr_next_s)
    );

    // Global history: mispredict repair beats the speculative shift.
    always_comb begin
        upd_shift_s  = {update_hist, update_taken};
        look_shift_s = {ghr_q, pred_taken};
        if (HIST_WIDTH == 0)                    ghr_d = {HW{1'b0}};
        else if (update && update_mispredict)   ghr_d = upd_shift_s[HW-1:0];
        else if (lookup_valid)                  ghr_d = look_shift_s[HW-1:0];
        else                                    ghr_d = ghr_q;
    end

    // GHR register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ghr_q <= {HW{1'b0}};
        else        ghr_q <= ghr_d;
    end

    // Valid bits and round-robin pointers; pointer moves only on a true eviction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < NSETS; s++) begin
                valid_q[s] <= {NWAYS{1'b0}};
                rr_q[s]    <= {N_WIDTH{1'b0}};
            end
        end else if (update && !u_hit_s && update_taken) begin
            valid_q[u_set_s][victim_s] <= 1'b1;
            if (!inv_found_s) rr_q[u_set_s] <= rr_q[u_set_s] + N_WIDTH'(1'b1);
        end
    end

    // Entry payload; meaningless until its valid bit is set, so no reset.
    always_ff @(posedge clk) begin
        if (update) begin
            if (u_hit_s) begin
                ctr_q[u_set_s][u_way_s] <= u_ctr_next_s;
                if (update_taken) target_q[u_set_s][u_way_s] <= update_target;
            end else if (update_taken) begin
                tag_q[u_set_s][victim_s]    <= u_tag_s;
                target_q[u_set_s][victim_s] <= update_target;
                ctr_q[u_set_s][victim_s]    <= CTR_WEAK;
            end
        end
    end

endmodule

// File: tb/tb_cpu_btb_predictor.sv
// Scoreboard bench for cpu_btb_predictor. Instance a_ has no history
// (plain indexing), instance b_ uses 4 history bits.
module tb_cpu_btb_predictor;

    logic clk = 1'b1;
    logic rst_n;

    // Free-running clock, negedge first so checks precede each rising edge.
    always #5 clk = ~clk;

    logic        a_lv, a_hit, a_taken, a_upd, a_utaken, a_umisp;
    logic [31:0] a_laddr, a_tgt, a_uaddr, a_utgt;
    logic [0:0]  a_hist, a_uhist;
    logic        b_lv, b_hit, b_taken, b_upd, b_utaken, b_umisp;
    logic [31:0] b_laddr, b_tgt, b_uaddr, b_utgt;
    logic [3:0]  b_hist, b_uhist;

    cpu_btb_predictor #(.HIST_WIDTH(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .lookup_valid(a_lv), .lookup_addr(a_laddr),
        .pred_hit(a_hit), .pred_taken(a_taken), .pred_target(a_tgt), .pred_hist(a_hist),
        .update(a_upd), .update_addr(a_uaddr), .update_hist(a_uhist),
        .update_taken(a_utaken), .update_target(a_utgt), .update_mispredict(a_umisp));

    cpu_btb_predictor #(.HIST_WIDTH(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .lookup_valid(b_lv), .lookup_addr(b_laddr),
        .pred_hit(b_hit), .pred_taken(b_taken), .pred_target(b_tgt), .pred_hist(b_hist),
        .update(b_upd), .update_addr(b_uaddr), .update_hist(b_uhist),
        .update_taken(b_utaken), .update_target(b_utgt), .update_mispredict(b_umisp));

    typedef struct packed {
        logic        hit;
        logic        taken;
        logic [31:0] tgt;
        logic [3:0]  hist;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   na = 0;
    int   nb = 0;

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (lookup %0d): got 0x%0h expected 0x%0h", name, idx, act, exp);
        end
    endtask

    // Monitor for instance a: every lookup presents one prediction.
    always @(negedge clk) begin
        if (a_lv) begin
            if (qa.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL a_unexpected (lookup %0d): got lookup expected none", na);
            end else begin
                exp_t e;
                e = qa.pop_front();
                check("a_hit",    na, {31'd0, a_hit},   {31'd0, e.hit});
                check("a_taken",  na, {31'd0, a_taken}, {31'd0, e.taken});
                check("a_target", na, a_tgt,            e.tgt);
                check("a_hist",   na, {31'd0, a_hist},  {28'd0, e.hist});
            end
            na++;
        end
    end

    // Monitor for instance b, including the history snapshot.
    always @(negedge clk) begin
        if (b_lv) begin
            if (qb.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL b_unexpected (lookup %0d): got lookup expected none", nb);
            end else begin
                exp_t e;
                e = qb.pop_front();
                check("b_hit",    nb, {31'd0, b_hit},   {31'd0, e.hit});
                check("b_taken",  nb, {31'd0, b_taken}, {31'd0, e.taken});
                check("b_target", nb, b_tgt,            e.tgt);
                check("b_hist",   nb, {28'd0, b_hist},  {28'd0, e.hist});
            end
            nb++;
        end
    end

    task automatic clear_inputs();
        a_lv = 1'b0; a_laddr = 32'd0; a_upd = 1'b0; a_uaddr = 32'd0; a_uhist = 1'b0;
        a_utaken = 1'b0; a_utgt = 32'd0; a_umisp = 1'b0;
        b_lv = 1'b0; b_laddr = 32'd0; b_upd = 1'b0; b_uaddr = 32'd0; b_uhist = 4'd0;
        b_utaken = 1'b0; b_utgt = 32'd0; b_umisp = 1'b0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        clear_inputs();
    endtask

    task automatic look_a(input logic [31:0] addr, input logic h, input logic t,
                          input logic [31:0] tg);
        a_lv = 1'b1; a_laddr = addr;
        qa.push_back('{hit: h, taken: t, tgt: tg, hist: 4'd0});
    endtask

    task automatic upd_a(input logic [31:0] addr, input logic t, input logic [31:0] tg);
        a_upd = 1'b1; a_uaddr = addr; a_utaken = t; a_utgt = tg;
    endtask

    task automatic look_b(input logic [31:0] addr, input logic h, input logic t,
                          input logic [31:0] tg, input logic [3:0] hist);
        b_lv = 1'b1; b_laddr = addr;
        qb.push_back('{hit: h, taken: t, tgt: tg, hist: hist});
    endtask

    task automatic upd_b(input logic [31:0] addr, input logic [3:0] hist, input logic t,
                         input logic [31:0] tg, input logic misp);
        b_upd = 1'b1; b_uaddr = addr; b_uhist = hist; b_utaken = t; b_utgt = tg;
        b_umisp = misp;
    endtask

    // Directed stimulus with hand-computed expectations.
    initial begin
        clear_inputs();
        rst_n = 1'b0;
        #1;
        look_a(32'h100, 1'b0, 1'b0, 32'h0);
        look_b(32'h100, 1'b0, 1'b0, 32'h0, 4'd0);
        cyc();
        rst_n = 1'b1;

        // Allocation, then counter walk 10 -> 01 -> 00 -> 00 (floor).
        look_a(32'h100, 1'b0, 1'b0, 32'h0);              cyc();
        upd_a(32'h100, 1'b1, 32'h200);                   cyc();
        look_a(32'h100, 1'b1, 1'b1, 32'h200);            cyc();
        upd_a(32'h100, 1'b0, 32'h0);                     cyc();
        look_a(32'h100, 1'b1, 1'b0, 32'h200);            cyc();
        upd_a(32'h100, 1'b0, 32'h0);                     cyc();
        look_a(32'h100, 1'b1, 1'b0, 32'h200);            cyc();
        upd_a(32'h100, 1'b0, 32'h0);                     cyc();
        look_a(32'h100, 1'b1, 1'b0, 32'h200);            cyc();
        // Same-cycle update: lookup sees the old counter 00 and old target.
        upd_a(32'h100, 1'b1, 32'h280);
        look_a(32'h100, 1'b1, 1'b0, 32'h200);            cyc();
        look_a(32'h100, 1'b1, 1'b0, 32'h280);            cyc();
        // Climb to 11, try to overflow, then one not-taken leaves 10.
        upd_a(32'h100, 1'b1, 32'h280);                   cyc();
        upd_a(32'h100, 1'b1, 32'h280);                   cyc();
        upd_a(32'h100, 1'b1, 32'h280);                   cyc();
        upd_a(32'h100, 1'b0, 32'h0);                     cyc();
        look_a(32'h100, 1'b1, 1'b1, 32'h280);            cyc();

        // Not-taken miss allocates nothing.
        upd_a(32'h300, 1'b0, 32'h999);                   cyc();
        look_a(32'h300, 1'b0, 1'b0, 32'h0);              cyc();

        // Set 1 conflicts: A,B fill ways 0,1; C evicts A (rr 0); D evicts B (rr 1).
        upd_a(32'h1004, 1'b1, 32'hA00);                  cyc();
        upd_a(32'h2004, 1'b1, 32'hB00);                  cyc();
        upd_a(32'h3004, 1'b1, 32'hC00);                  cyc();
        look_a(32'h1004, 1'b0, 1'b0, 32'h0);             cyc();
        look_a(32'h2004, 1'b1, 1'b1, 32'hB00);           cyc();
        look_a(32'h3004, 1'b1, 1'b1, 32'hC00);           cyc();
        upd_a(32'h4004, 1'b1, 32'hD00);                  cyc();
        look_a(32'h2004, 1'b0, 1'b0, 32'h0);             cyc();
        look_a(32'h3004, 1'b1, 1'b1, 32'hC00);           cyc();
        look_a(32'h4004, 1'b1, 1'b1, 32'hD00);           cyc();

        // gshare: entries for 0x100 at history 0, 1, 3 (sets 0, 1, 3).
        upd_b(32'h100, 4'd0, 1'b1, 32'h500, 1'b0);       cyc();
        upd_b(32'h100, 4'd1, 1'b1, 32'h500, 1'b0);       cyc();
        upd_b(32'h100, 4'd3, 1'b1, 32'h500, 1'b0);       cyc();
        look_b(32'h100, 1'b1, 1'b1, 32'h500, 4'b0000);   cyc();
        look_b(32'h100, 1'b1, 1'b1, 32'h500, 4'b0001);   cyc();
        look_b(32'h100, 1'b1, 1'b1, 32'h500, 4'b0011);   cyc();
        // Repair in the same cycle as a lookup: repair wins.
        look_b(32'h100, 1'b0, 1'b0, 32'h0, 4'b0111);
        upd_b(32'h300, 4'b0001, 1'b0, 32'h0, 1'b1);      cyc();
        look_b(32'h100, 1'b0, 1'b0, 32'h0, 4'b0010);     cyc();

        // Asynchronous reset mid-cycle: outputs drop before any clock edge.
        look_a(32'h3004, 1'b0, 1'b0, 32'h0);
        look_b(32'h100, 1'b0, 1'b0, 32'h0, 4'd0);
        #2 rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        look_a(32'h3004, 1'b0, 1'b0, 32'h0);
        look_b(32'h100, 1'b0, 1'b0, 32'h0, 4'd0);        cyc();
        look_a(32'h4004, 1'b0, 1'b0, 32'h0);             cyc();
        look_a(32'h100, 1'b0, 1'b0, 32'h0);              cyc();
        cyc();

        check("a_queue_drained", 0, qa.size(), 32'd0);
        check("b_queue_drained", 0, qb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
